reaction_ctrl: RTL

Game sequencer for the F1 start-lights reaction timer. It starts the light sequence when the player presses the button and detects a jump start during the sequence. Once the lights go out it times the player's reaction in milliseconds, then holds the result and the session best for the BCD display path. It sits between the button input, the light-sequence FSM (start/abort in, lights-out back), the millisecond tick generator and the binary-to-BCD converter.

---
 rtl/reaction_ctrl_pkg.sv | 16 +
 rtl/reaction_ctrl_btn_sync_edge.sv | 27 ++
 rtl/reaction_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_pkg.sv
// Shared types and default sizing for the F1 start-lights reaction timer.
package reaction_ctrl_pkg;

  localparam int RC_W       = 14;
  localparam int RC_MAX_MS  = 9999;
  localparam int RC_HOLD_MS = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REACT = 3'd2,
    ST_SHOW  = 3'd3,
    ST_FAULT = 3'd4
  } rc_state_e;

endpackage

// File: rtl/reaction_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for the async button plus a registered rising-edge pulse.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q, press_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: arms the light sequence, catches jump starts,
// counts reaction milliseconds and keeps last/best results.
module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int W       = RC_W,
  parameter int MAX_MS  = RC_MAX_MS,
  parameter int HOLD_MS = RC_HOLD_MS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_ms,
  input  logic         btn,
  input  logic         lights_out,
  output logic         start_seq,
  output logic         abort_seq,
  output logic [W-1:0] react_ms,
  output logic [W-1:0] best_ms,
  output logic         result_valid,
  output logic         false_start,
  output logic         timeout,
  output logic         busy
);

  localparam logic [W-1:0] MAX_V  = W'(MAX_MS);
  localparam logic [W-1:0] HOLD_V = W'(HOLD_MS);

  rc_state_e    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0] hold_q, hold_d;
  logic [W-1:0] react_q, react_d, best_q, best_d;
  logic         start_q, start_d, abort_q, abort_d, rv_q, rv_d;
  logic         fs_q, fs_d, to_q, to_d, busy_q, busy_d, to_set;
  logic         press;

  btn_sync_edge u_btn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn),
    .press_o (press)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    react_d = react_q;
    best_d  = best_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    rv_d    = 1'b0;
    to_set  = 1'b0;
    cnt_inc = (cnt_q >= MAX_V) ? MAX_V : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          start_d = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // a press coinciding with lights_out still counts as a jump start
        if (press) begin
          abort_d = 1'b1;
          hold_d  = HOLD_V;
          state_d = ST_FAULT;
        end else if (lights_out) begin
          cnt_d   = '0;
          state_d = ST_REACT;
        end
      end
      ST_REACT: begin
        if (press) begin
          react_d = cnt_q;
          rv_d    = 1'b1;
          if (cnt_q < best_q) best_d = cnt_q;
          hold_d  = HOLD_V;
          state_d = ST_SHOW;
        end else if (cnt_q >= MAX_V || (tick_ms && cnt_inc >= MAX_V)) begin
          react_d = MAX_V;
          rv_d    = 1'b1;
          to_set  = 1'b1;
          hold_d  = HOLD_V;
          state_d = ST_SHOW;
        end else if (tick_ms) begin
          cnt_d = cnt_inc;
        end
      end
      ST_SHOW, ST_FAULT: begin
        if (tick_ms && hold_q != '0) hold_d = hold_q - 1'b1;
        if (press && hold_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    to_d   = to_set | (to_q & (state_d == ST_SHOW));
    fs_d   = (state_d == ST_FAULT);
    busy_d = (state_d == ST_ARMED) || (state_d == ST_REACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      react_q <= '0;
      best_q  <= MAX_V;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      rv_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      react_q <= react_d;
      best_q  <= best_d;
      start_q <= start_d;
      abort_q <= abort_d;
      rv_q    <= rv_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign start_seq    = start_q;
  assign abort_seq    = abort_q;
  assign result_valid = rv_q;
  assign react_ms     = react_q;
  assign best_ms      = best_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign busy         = busy_q;

endmodule
